csi_rx_axis_framer: RTL and testbench

- Sits directly downstream of the CSI-2 RX word aligner, in the byte-clock domain.
- Consumes its unthrottled 32-bit payload stream (VALID/DOUT) and frame-start pulse (FSYNC).
- Produces a true AXI4-Stream video interface with backpressure: TUSER marks start of frame, TLAST marks end of line.
- A local FIFO absorbs TREADY stalls. Line/frame counters and a sticky overflow flag are provided for debug.

---
 rtl/csi_rx_axis_framer.sv | 168 ++++++++++++++++
 tb/tb_csi_rx_axis_framer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/csi_rx_axis_framer.sv
// CSI-2 RX payload framer: turns the word aligner's unthrottled VALID/DOUT
// stream plus FSYNC into an AXI4-Stream video interface (TUSER = start of
// frame, TLAST = end of line). A FIFO absorbs TREADY stalls. Line/frame
// counters and a sticky overflow flag are provided for debug.
module csi_rx_axis_framer #(
    parameter int FIFO_DEPTH = 64,
    parameter int FIFO_AW    = 6
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               FSYNC,
    input  logic               DIN_VALID,
    input  logic [31:0]        DIN,
    output logic [31:0]        AXIS_TDATA,
    output logic               AXIS_TVALID,
    input  logic               AXIS_TREADY,
    output logic               AXIS_TUSER,
    output logic               AXIS_TLAST,
    input  logic               OVF_CLR,
    output logic               OVERFLOW,
    output logic [15:0]        LINE_CNT,
    output logic [15:0]        FRAME_CNT,
    output logic [FIFO_AW:0]   FIFO_LEVEL
);

    localparam logic [FIFO_AW:0]   DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = (FIFO_AW)'(1);

    // Hold stage: the last word of a line is only known once DIN_VALID drops.
    logic [31:0]        hold_data_r;
    logic               hold_user_r;
    logic               hv_r;
    logic               sof_pend_r;

    // FIFO storage plus a registered output stage; word = {user, last, data}.
    logic [33:0]        mem_r [0:FIFO_DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   level_r;
    logic               out_valid_r;
    logic [33:0]        out_word_r;

    logic               overflow_r;
    logic [15:0]        line_cnt_r;
    logic [15:0]        frame_cnt_r;

    logic               push_s;
    logic               push_last_s;
    logic [33:0]        push_word_s;
    logic               pop_s;
    logic               full_s;
    logic               accept_s;
    logic               drop_s;
    logic               mem_empty_s;
    logic               load_out_s;

    // Decide whether the hold register is pushed this cycle, and with which last flag.
    always_comb begin
        push_s      = 1'b0;
        push_last_s = 1'b0;
        if (DIN_VALID) begin
            push_s      = hv_r;
            push_last_s = 1'b0;
        end else if (hv_r) begin
            push_s      = 1'b1;
            push_last_s = 1'b1;
        end else begin
            push_s      = 1'b0;
            push_last_s = 1'b0;
        end
    end

    assign push_word_s = {hold_user_r, push_last_s, hold_data_r};

    // FIFO control: a pop frees a slot in the same cycle, so push-at-full with pop is accepted.
    always_comb begin
        pop_s       = out_valid_r & AXIS_TREADY;
        full_s      = (level_r == DEPTH_L);
        accept_s    = push_s & (~full_s | pop_s);
        drop_s      = push_s & full_s & ~pop_s;
        mem_empty_s = (level_r == {{FIFO_AW{1'b0}}, out_valid_r});
        load_out_s  = (~out_valid_r | pop_s) & ~mem_empty_s;
    end

    // Hold register, hold-valid flag and pending start-of-frame marker.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_data_r <= 32'h0000_0000;
            hold_user_r <= 1'b0;
            hv_r        <= 1'b0;
            sof_pend_r  <= 1'b0;
        end else if (DIN_VALID) begin
            hold_data_r <= DIN;
            hold_user_r <= sof_pend_r | FSYNC;
            hv_r        <= 1'b1;
            sof_pend_r  <= 1'b0;
        end else begin
            hv_r        <= 1'b0;
            sof_pend_r  <= sof_pend_r | FSYNC;
        end
    end

    // FIFO payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= push_word_s;
        end
    end

    // FIFO pointers, total occupancy (storage plus output stage) and output stage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_r    <= {FIFO_AW{1'b0}};
            rd_ptr_r    <= {FIFO_AW{1'b0}};
            level_r     <= {(FIFO_AW+1){1'b0}};
            out_valid_r <= 1'b0;
            out_word_r  <= 34'h0_0000_0000;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            case ({accept_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
            if (load_out_s) begin
                out_valid_r <= 1'b1;
                out_word_r  <= mem_r[rd_ptr_r];
                rd_ptr_r    <= rd_ptr_r + PTR_ONE;
            end else if (pop_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Debug counters follow input framing (push attempts, dropped or not); overflow is sticky.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            line_cnt_r  <= 16'h0000;
            frame_cnt_r <= 16'h0000;
            overflow_r  <= 1'b0;
        end else begin
            if (push_s && hold_user_r) begin
                line_cnt_r  <= push_last_s ? 16'h0001 : 16'h0000;
                frame_cnt_r <= frame_cnt_r + 16'h0001;
            end else if (push_s && push_last_s && (line_cnt_r != 16'hFFFF)) begin
                line_cnt_r  <= line_cnt_r + 16'h0001;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (OVF_CLR) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign AXIS_TVALID = out_valid_r;
    assign AXIS_TUSER  = out_word_r[33];
    assign AXIS_TLAST  = out_word_r[32];
    assign AXIS_TDATA  = out_word_r[31:0];
    assign OVERFLOW    = overflow_r;
    assign LINE_CNT    = line_cnt_r;
    assign FRAME_CNT   = frame_cnt_r;
    assign FIFO_LEVEL  = level_r;

endmodule

// File: tb/tb_csi_rx_axis_framer.sv
// Directed testbench for csi_rx_axis_framer. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_csi_rx_axis_framer;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          FSYNC;
    logic          DIN_VALID;
    logic [31:0]   DIN;
    logic [31:0]   AXIS_TDATA;
    logic          AXIS_TVALID;
    logic          AXIS_TREADY;
    logic          AXIS_TUSER;
    logic          AXIS_TLAST;
    logic          OVF_CLR;
    logic          OVERFLOW;
    logic [15:0]   LINE_CNT;
    logic [15:0]   FRAME_CNT;
    logic [AW:0]   FIFO_LEVEL;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [33:0]   beats[$];
    logic          prev_stall = 1'b0;
    logic [33:0]   prev_word  = 34'h0;
    bit            toggle_rdy = 1'b0;

    csi_rx_axis_framer #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .FSYNC(FSYNC), .DIN_VALID(DIN_VALID), .DIN(DIN),
        .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID), .AXIS_TREADY(AXIS_TREADY),
        .AXIS_TUSER(AXIS_TUSER), .AXIS_TLAST(AXIS_TLAST), .OVF_CLR(OVF_CLR),
        .OVERFLOW(OVERFLOW), .LINE_CNT(LINE_CNT), .FRAME_CNT(FRAME_CNT),
        .FIFO_LEVEL(FIFO_LEVEL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Record handshaken beats and verify outputs hold steady across stalls.
    always @(negedge CLK) begin
        if (prev_stall && RST_N) begin
            check("stall_tvalid", {63'h0, AXIS_TVALID}, 64'h1);
            check("stall_word", {30'h0, AXIS_TUSER, AXIS_TLAST, AXIS_TDATA}, {30'h0, prev_word});
        end
        if (AXIS_TVALID && AXIS_TREADY && RST_N) begin
            beats.push_back({AXIS_TUSER, AXIS_TLAST, AXIS_TDATA});
        end
        prev_stall = AXIS_TVALID && !AXIS_TREADY && RST_N;
        prev_word  = {AXIS_TUSER, AXIS_TLAST, AXIS_TDATA};
    end

    task automatic cyc(input logic fs, input logic v, input logic [31:0] d);
        FSYNC     = fs;
        DIN_VALID = v;
        DIN       = d;
        if (toggle_rdy) AXIS_TREADY = ~AXIS_TREADY;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0; FSYNC = 1'b0; DIN_VALID = 1'b0; DIN = 32'h0;
        OVF_CLR = 1'b0; AXIS_TREADY = 1'b0; toggle_rdy = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        beats.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_tvalid", {63'h0, AXIS_TVALID}, 64'h0);
        check("rst_outs", {28'h0, AXIS_TUSER, AXIS_TLAST, OVERFLOW, AXIS_TDATA}, 64'h0);
        check("rst_cnts", {25'h0, FIFO_LEVEL, LINE_CNT, FRAME_CNT}, 64'h0);

        // Three 4-word lines, TREADY high
        AXIS_TREADY = 1'b1;
        cyc(1'b1, 1'b0, 32'h0);
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'(l * 4 + i));
            idle(2);
        end
        idle(6);
        check("t1_nbeats", 64'(beats.size()), 64'd12);
        for (int k = 0; k < 12 && k < beats.size(); k++)
            check("t1_beat", {30'h0, beats[k]}, {30'h0, (k == 0), (k % 4 == 3), 32'(k)});
        check("t1_line_cnt", {48'h0, LINE_CNT}, 64'd3);
        check("t1_frame_cnt", {48'h0, FRAME_CNT}, 64'd1);
        check("t1_overflow", {63'h0, OVERFLOW}, 64'h0);

        // Single-word line with FSYNC in the same cycle
        do_reset();
        AXIS_TREADY = 1'b1;
        cyc(1'b1, 1'b1, 32'hDEADBEEF);
        check("t2_tvalid_c0", {63'h0, AXIS_TVALID}, 64'h0);
        idle(1);
        check("t2_tvalid_c1", {63'h0, AXIS_TVALID}, 64'h0);
        check("t2_line_cnt", {48'h0, LINE_CNT}, 64'd1);
        check("t2_frame_cnt", {48'h0, FRAME_CNT}, 64'd1);
        idle(1);
        check("t2_tvalid_c2", {63'h0, AXIS_TVALID}, 64'h1);
        check("t2_word", {30'h0, AXIS_TUSER, AXIS_TLAST, AXIS_TDATA}, {30'h0, 2'b11, 32'hDEADBEEF});
        idle(3);
        check("t2_nbeats", 64'(beats.size()), 64'd1);

        // 70-word line into a stalled 64-entry FIFO
        do_reset();
        cyc(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 70; i++) cyc(1'b0, 1'b1, 32'(i));
        idle(3);
        check("t3_level", {57'h0, FIFO_LEVEL}, 64'd64);
        check("t3_overflow", {63'h0, OVERFLOW}, 64'h1);
        check("t3_line_cnt", {48'h0, LINE_CNT}, 64'd1);
        OVF_CLR = 1'b1;
        idle(1);
        OVF_CLR = 1'b0;
        check("t3_ovf_clr", {63'h0, OVERFLOW}, 64'h0);
        AXIS_TREADY = 1'b1;
        idle(70);
        check("t3_nbeats", 64'(beats.size()), 64'd64);
        for (int k = 0; k < 64 && k < beats.size(); k++)
            check("t3_beat", {30'h0, beats[k]}, {30'h0, (k == 0), 1'b0, 32'(k)});
        check("t3_level_empty", {57'h0, FIFO_LEVEL}, 64'd0);

        // TREADY toggling every cycle over two 8-word lines
        do_reset();
        AXIS_TREADY = 1'b1;
        toggle_rdy  = 1'b1;
        cyc(1'b1, 1'b0, 32'h0);
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 32'h10 + 32'(l * 8 + i));
            idle(2);
        end
        idle(40);
        toggle_rdy  = 1'b0;
        AXIS_TREADY = 1'b1;
        idle(4);
        check("t4_nbeats", 64'(beats.size()), 64'd16);
        for (int k = 0; k < 16 && k < beats.size(); k++)
            check("t4_beat", {30'h0, beats[k]}, {30'h0, (k == 0), (k % 8 == 7), 32'h10 + 32'(k)});
        check("t4_overflow", {63'h0, OVERFLOW}, 64'h0);
        check("t4_line_cnt", {48'h0, LINE_CNT}, 64'd2);

        // Reset mid-line with 10 words buffered and one in the hold stage
        do_reset();
        cyc(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 32'h200 + 32'(i));
        check("t5_level_pre", {57'h0, FIFO_LEVEL}, 64'd10);
        check("t5_tvalid_pre", {63'h0, AXIS_TVALID}, 64'h1);
        RST_N = 1'b0;
        #1;
        check("t5_tvalid_rst", {63'h0, AXIS_TVALID}, 64'h0);
        check("t5_level_rst", {57'h0, FIFO_LEVEL}, 64'd0);
        DIN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        beats.delete();
        AXIS_TREADY = 1'b1;
        cyc(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h300 + 32'(i));
        idle(6);
        check("t5_nbeats", 64'(beats.size()), 64'd3);
        for (int k = 0; k < 3 && k < beats.size(); k++)
            check("t5_beat", {30'h0, beats[k]}, {30'h0, (k == 0), (k == 2), 32'h300 + 32'(k)});

        // FRAME_CNT wrap: one-word frames with FSYNC on every word
        do_reset();
        AXIS_TREADY = 1'b1;
        for (int i = 0; i < 65535; i++) cyc(1'b1, 1'b1, 32'(i));
        idle(1);
        check("t6_frame_ffff", {48'h0, FRAME_CNT}, 64'hFFFF);
        check("t6_line_ffff", {48'h0, LINE_CNT}, 64'd1);
        cyc(1'b1, 1'b1, 32'hFFFF);
        idle(1);
        check("t6_frame_wrap", {48'h0, FRAME_CNT}, 64'h0);
        check("t6_line_wrap", {48'h0, LINE_CNT}, 64'd1);
        idle(4);
        check("t6_nbeats", 64'(beats.size()), 64'd65536);
        check("t6_overflow", {63'h0, OVERFLOW}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
